// File: rtl/alu_share_pkg.sv
// Shared types for the two-requester ALU sharing controller: op codes and FSM states.
package alu_share_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LTU = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a sole request wins outright, a tie goes to the side named by ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// One W-bit ALU shared by two requesters: arbitrate in IDLE, compute in EXEC, hold the result in RESP.
// Define ALU_LOCK_EN to let a requester keep the grant for its next request via req_lock.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [5:0]     req_op,
    input  logic [1:0]     req_lock,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_out,
    output logic           rsp_cf,
    output logic           rsp_of,
    output logic           rsp_zf
);

    st_e           state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    alu_op_e       op_q, op_d;
    logic [W-1:0]  out_q, out_d;
    logic          cf_q, cf_d, of_q, of_d, zf_q, zf_d;

    logic [1:0]    gnt;
    logic          gnt_id;
    logic          arb_ptr;

`ifdef ALU_LOCK_EN
    logic          lock_q, lock_d;

    // A locked previous grant turns the tie-break toward its owner for one arbitration.
    assign arb_ptr = lock_q ? id_q : ptr_q;
`else
    logic          lock_unused;

    assign lock_unused = |req_lock;
    assign arb_ptr     = ptr_q;
`endif

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (arb_ptr),
        .gnt (gnt)
    );

    assign gnt_id = gnt[1];

    logic          is_sub;
    logic [W-1:0]  b_x;
    logic [W:0]    sum;
    logic [W-1:0]  res;
    logic          res_cf, res_of;

    // Subtraction reuses the adder as a + ~b + 1, so cf is the raw carry (1 = no borrow).
    assign is_sub = (op_q == OP_SUB);
    assign b_x    = is_sub ? ~b_q : b_q;
    assign sum    = {1'b0, a_q} + {1'b0, b_x} + {{W{1'b0}}, is_sub};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        res    = '0;
        res_cf = 1'b0;
        res_of = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB: begin
                res    = sum[W-1:0];
                res_cf = sum[W];
                res_of = (a_q[W-1] == b_x[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            OP_NOT: res = ~a_q;
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_LTU: res = {{(W-1){1'b0}}, (a_q < b_q)};
            OP_EQ:  res = {{(W-1){1'b0}}, (a_q == b_q)};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        out_d     = out_q;
        cf_d      = cf_q;
        of_d      = of_q;
        zf_d      = zf_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
`ifdef ALU_LOCK_EN
        lock_d    = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready = rst ? 2'b00 : gnt;
                if (|gnt) begin
                    id_d    = gnt_id;
                    a_d     = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
                    b_d     = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
                    op_d    = alu_op_e'(gnt_id ? req_op[5:3] : req_op[2:0]);
                    state_d = EXEC;
`ifdef ALU_LOCK_EN
                    lock_d  = gnt_id ? req_lock[1] : req_lock[0];
                    if (!lock_d) begin
                        ptr_d = ~gnt_id;
                    end
`else
                    ptr_d   = ~gnt_id;
`endif
                end
            end
            EXEC: begin
                out_d   = res;
                cf_d    = res_cf;
                of_d    = res_of;
                zf_d    = (res == '0);
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = !rst;
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            out_q   <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
`ifdef ALU_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            out_q   <= out_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
`ifdef ALU_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    // NOTE: operand registers are deliberately not reset; they are only read after a grant loads them.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign rsp_out = out_q;
    assign rsp_cf  = cf_q;
    assign rsp_of  = of_q;
    assign rsp_zf  = zf_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed cases with literal results plus a random run
// checked every cycle against an arithmetic reference model.
module tb_alu_share_ctrl;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [5:0]     req_op = '0;
    logic [1:0]     req_lock = '0;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready = '0;
    logic [W-1:0]   rsp_out;
    logic           rsp_cf, rsp_of, rsp_zf;

    alu_share_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_cf    (rsp_cf),
        .rsp_of    (rsp_of),
        .rsp_zf    (rsp_zf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one transaction in flight, tracked by cycles since acceptance.
    bit m_init = 0;
    bit m_busy = 0;
    int m_cnt = 0;
    int m_owner = 0;
    int m_out = 0, m_cf = 0, m_of = 0, m_zf = 0;
    int m_pref = 0;
    bit m_lock_act = 0;
    int m_lock_id = 0;

    function automatic int m_winner(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_LOCK_EN
        if (m_lock_act) return m_lock_id;
`endif
        return m_pref;
    endfunction

    function automatic int to_signed(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    task automatic ref_alu(input int a, input int b, input int op,
                           output int o, output int cf, output int of, output int zf);
        int s;
        cf = 0;
        of = 0;
        o  = 0;
        case (op)
            0: begin
                s  = a + b;
                o  = s % M;
                cf = (s >= M) ? 1 : 0;
                s  = to_signed(a) + to_signed(b);
                of = (s < -M / 2 || s >= M / 2) ? 1 : 0;
            end
            1: begin
                o  = (a - b + M) % M;
                cf = (a >= b) ? 1 : 0;
                s  = to_signed(a) - to_signed(b);
                of = (s < -M / 2 || s >= M / 2) ? 1 : 0;
            end
            2: o = M - 1 - a;
            3: o = a & b;
            4: o = a | b;
            5: o = a ^ b;
            6: o = (a < b) ? 1 : 0;
            default: o = (a == b) ? 1 : 0;
        endcase
        zf = (o == 0) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_init     = 1;
            m_busy     = 0;
            m_pref     = 0;
            m_lock_act = 0;
        end else if (m_init) begin
            if (!m_busy) begin
                g = m_winner(req_valid);
                if (g >= 0) begin
                    m_busy  = 1;
                    m_cnt   = 1;
                    m_owner = g;
                    ref_alu(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), int'(req_op[g*3 +: 3]),
                            m_out, m_cf, m_of, m_zf);
`ifdef ALU_LOCK_EN
                    if (req_lock[g]) begin
                        m_lock_act = 1;
                        m_lock_id  = g;
                    end else begin
                        m_lock_act = 0;
                        m_pref     = 1 - g;
                    end
`else
                    m_pref = 1 - g;
`endif
                end
            end else if (m_cnt >= 2 && rsp_ready[m_owner]) begin
                m_busy = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        int g, exp_r, exp_v;
        if (m_init) begin
            exp_r = 0;
            if (!rst && !m_busy) begin
                g = m_winner(req_valid);
                if (g >= 0) exp_r = 1 << g;
            end
            check("req_ready", int'(req_ready), exp_r);
            exp_v = (!rst && m_busy && m_cnt >= 2) ? (1 << m_owner) : 0;
            check("rsp_valid", int'(rsp_valid), exp_v);
            if (exp_v != 0) begin
                check("rsp_out", int'(rsp_out), m_out);
                check("rsp_cf", int'(rsp_cf), m_cf);
                check("rsp_of", int'(rsp_of), m_of);
                check("rsp_zf", int'(rsp_zf), m_zf);
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_lock  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one request and check the response against literal values; caller is just after posedge.
    task automatic do_op(input int id, input int a, input int b, input int op,
                         input int eo, input int ecf, input int eof, input int ezf, input int hold);
        bit got;
        req_a[id*W +: W] = a[W-1:0];
        req_b[id*W +: W] = b[W-1:0];
        req_op[id*3 +: 3] = op[2:0];
        req_valid = 2'(1 << id);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        check("accept", int'(got), 1);
        if (!got) begin
            req_valid = '0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("exec_no_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        check("lat_rsp_valid", int'(rsp_valid), 1 << id);
        check("lit_out", int'(rsp_out), eo);
        check("lit_cf", int'(rsp_cf), ecf);
        check("lit_of", int'(rsp_of), eof);
        check("lit_zf", int'(rsp_zf), ezf);
        if (hold > 0) req_valid = 2'(1 << (1 - id));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", int'(rsp_valid), 1 << id);
            check("hold_out", int'(rsp_out), eo);
            check("hold_flags", int'({rsp_cf, rsp_of, rsp_zf}), (ecf << 2) | (eof << 1) | ezf);
            check("hold_ready", int'(req_ready), 0);
        end
        req_valid = '0;
        rsp_ready = 2'(1 << id);
        @(posedge clk);
        #1 rsp_ready = '0;
    endtask

    // Hold both requesters valid and record who wins each arbitration.
    task automatic collect_grants(input int n, output int grants[$]);
        logic [31:0] r;
        grants    = {};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 100 && grants.size() < n; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
            @(posedge clk);
            #1;
            r = $urandom;
            req_a  = r[0 +: 2*W];
            req_b  = r[8 +: 2*W];
            req_op = r[16 +: 6];
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    initial begin
        int grants[$];
        logic [31:0] r, r2;
        bit got;

        do_reset();
        @(negedge clk);
        check("reset_ready", int'(req_ready), 0);
        check("reset_valid", int'(rsp_valid), 0);
        check("reset_out", int'(rsp_out), 0);
        check("reset_flags", int'({rsp_cf, rsp_of, rsp_zf}), 0);
        @(posedge clk);
        #1;

        do_op(0, 7, 9, 0, 0, 1, 0, 1, 0);
        do_op(1, 3, 5, 1, 14, 0, 0, 0, 0);
        do_op(1, 8, 1, 1, 7, 1, 1, 0, 5);
        do_op(0, 6, 6, 2, 9, 0, 0, 0, 0);
        do_op(0, 6, 6, 3, 6, 0, 0, 0, 0);
        do_op(1, 6, 6, 4, 6, 0, 0, 0, 0);
        do_op(0, 6, 6, 5, 0, 0, 0, 1, 0);
        do_op(1, 6, 6, 6, 0, 0, 0, 1, 0);
        do_op(0, 6, 6, 7, 1, 0, 0, 0, 0);
        do_op(0, 15, 15, 0, 14, 1, 0, 0, 0);
        do_op(1, 7, 1, 0, 8, 0, 1, 0, 0);
        do_op(0, 2, 9, 6, 1, 0, 0, 0, 0);

        do_reset();
        collect_grants(8, grants);
        check("alt_count", grants.size(), 8);
        foreach (grants[i]) check("alt_grant", grants[i], i % 2);

        do_reset();
        req_a[W-1:0] = 4'd5;
        req_b[W-1:0] = 4'd5;
        req_op[2:0]  = 3'd0;
        req_valid    = 2'b01;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        check("mid_rst_accept", int'(got), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        rsp_ready = 2'b11;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge clk);
        #1 rsp_ready = '0;

`ifdef ALU_LOCK_EN
        do_reset();
        req_lock = 2'b01;
        collect_grants(3, grants);
        req_lock = 2'b00;
        check("lock_count", grants.size(), 3);
        foreach (grants[i]) check("lock_grant", grants[i], 0);
`endif

        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            r  = $urandom;
            r2 = $urandom;
            req_valid = r[1:0];
            rsp_ready = (r[4:2] == 3'd0) ? 2'b00 : r[6:5];
            req_lock  = r[8:7];
            req_op    = r[14:9];
            req_a     = r[15 +: 2*W];
            req_b     = r2[0 +: 2*W];
            rst       = (r2[15:10] == 6'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
